recir_idle_lanes: RTL

- Parametrised successor of the 4-lane recirculation stage in the PCIe physical-layer datapath.
- Routes N lanes of W-bit words either to the mux path (link active) or to the recirculation/probe path (link idle).
- Adds a debounced activity state machine, per-lane valid handling and registered outputs.
- Sits between the serial-parallel converter and the byte-striping mux.

---
 rtl/recir_idle_lanes_pkg.sv | 19 +
 rtl/recir_idle_lanes_if.sv | 30 +++
 rtl/recir_idle_lanes_lane.sv | 37 +++
 rtl/recir_idle_lanes.sv | 116 +++++++++++
 4 files changed

// File: rtl/recir_idle_lanes_pkg.sv
// Shared constants and state encodings for the idle/active lane recirculation stage.
package recir_idle_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned DEF_LANES = 4;
    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    // Words route to the recirculation path in every state except ACTIVE.
    function automatic logic is_recirc(input logic [STATE_W-1:0] st);
        return st != ST_ACTIVE;
    endfunction

endpackage

// File: rtl/recir_idle_lanes_if.sv
// Lane bus between the serial-parallel stage, this block and the striping mux.
interface recir_idle_lanes_if
    import recir_idle_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = 16
);

    logic                     valido;
    logic [LANES*WIDTH-1:0]   data_in;
    logic [LANES-1:0]         valid_in;
    logic [LANES*WIDTH-1:0]   data_outm;
    logic [LANES-1:0]         valid_outm;
    logic [LANES*WIDTH-1:0]   data_outt;
    logic [LANES-1:0]         valid_outt;
    logic [STATE_W-1:0]       state_o;
    logic [CNT_W-1:0]         recir_cnt;

    modport master (
        output valido, data_in, valid_in,
        input  data_outm, valid_outm, data_outt, valid_outt, state_o, recir_cnt
    );

    modport slave (
        input  valido, data_in, valid_in,
        output data_outm, valid_outm, data_outt, valid_outt, state_o, recir_cnt
    );

endinterface

// File: rtl/recir_idle_lanes_lane.sv
// One lane: registers the word and valid onto the mux path or the recirculation path.
module recir_lane
    import recir_idle_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk1f,
    input  logic             reset,
    input  logic             sel_mux,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_outm,
    output logic             valid_outm,
    output logic [WIDTH-1:0] data_outt,
    output logic             valid_outt
);

    always_ff @(posedge clk1f) begin
        if (reset) begin
            data_outm  <= '0;
            valid_outm <= 1'b0;
            data_outt  <= '0;
            valid_outt <= 1'b0;
        end else if (sel_mux) begin
            data_outm  <= data_in;
            valid_outm <= valid_in;
            data_outt  <= '0;
            valid_outt <= 1'b0;
        end else begin
            data_outm  <= '0;
            valid_outm <= 1'b0;
            data_outt  <= data_in;
            valid_outt <= valid_in;
        end
    end

endmodule

// File: rtl/recir_idle_lanes.sv
// Idle/active lane router with debounced activity FSM; optional recirculation
// counter enabled by defining RECIR_IDLE_CNT_EN.
module recir_idle_lanes
    import recir_idle_pkg::*;
#(
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned ACT_CYCLES = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk1f,
    input  logic             reset,
    recir_idle_lanes_if.slave bus
);

    localparam int unsigned ACT_W = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [ACT_W-1:0]   act_q, act_d;
    logic               sel_mux;

    logic [LANES*WIDTH-1:0] dm, dt;
    logic [LANES-1:0]       vm, vt;

    always_ff @(posedge clk1f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        act_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valido) begin
                    if (ACT_CYCLES == 1) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_ARM;
                        act_d   = ACT_W'(1);
                    end
                end
            end
            ST_ARM: begin
                if (!bus.valido) begin
                    state_d = ST_IDLE;
                end else if (act_q == ACT_W'(ACT_CYCLES - 1)) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_ARM;
                    act_d   = act_q + ACT_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (bus.valido) begin
                    state_d = ST_ACTIVE;
                end
            end
            // The unused encoding falls back to IDLE on the next edge.
            default: begin
                state_d = ST_IDLE;
                act_d   = '0;
            end
        endcase
    end

    // Steering follows the pre-edge state so a word captured on the edge that
    // leaves ACTIVE still lands on the mux path.
    assign sel_mux = !is_recirc(state_q);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        recir_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk1f      (clk1f),
            .reset      (reset),
            .sel_mux    (sel_mux),
            .data_in    (bus.data_in[i*WIDTH +: WIDTH]),
            .valid_in   (bus.valid_in[i]),
            .data_outm  (dm[i*WIDTH +: WIDTH]),
            .valid_outm (vm[i]),
            .data_outt  (dt[i*WIDTH +: WIDTH]),
            .valid_outt (vt[i])
        );
    end

    assign bus.data_outm  = dm;
    assign bus.valid_outm = vm;
    assign bus.data_outt  = dt;
    assign bus.valid_outt = vt;
    assign bus.state_o    = state_q;

`ifdef RECIR_IDLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating count of recirculated cycles carrying at least one valid word.
    always_ff @(posedge clk1f) begin
        if (reset) begin
            cnt_q <= '0;
        end else if ((state_q == ST_IDLE || state_q == ST_ARM) && (|bus.valid_in)
                     && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.recir_cnt = cnt_q;
`else
    assign bus.recir_cnt = '0;
`endif

endmodule
